// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder
//
// Turns per-channel 8-bit intensities into Bernoulli rate-coded spike trains
// that feed the spiking neuron's inputs[] and learn pins. Each run lasts
// `window` timesteps, one timestep per clock. A 16-bit Galois LFSR supplies
// the random bytes and is reseeded on every start, so identical windows give
// identical spike trains.
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous reset, active low
//   load_valid  offer a write of one channel intensity
//   load_ready  high only while idle
//   load_chan   target channel; indices >= CHANNELS are dropped
//   load_value  intensity value
//   start       begin a window (sampled only while idle)
//   window      window length in timesteps, sampled with start
//   learn_en    learn enable for the window, sampled with start
//   spikes      registered spike vector, bit i drives neuron inputs[i]
//   learn       registered learn pin
//   busy        high while the window runs
//   done        one-cycle pulse at the end of the window
//
// Build option: define SPIKE_ENC_REFRACTORY_EN to add a one-timestep
// refractory period per channel (at most one spike every two timesteps).

module spike_rate_encoder #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned VAL_W    = 8,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [2:0]          load_chan,
    input  logic [VAL_W-1:0]    load_value,
    input  logic                start,
    input  logic [7:0]          window,
    input  logic                learn_en,
    output logic [CHANNELS-1:0] spikes,
    output logic                learn,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [15:0] LfsrTaps = 16'hB400;

    state_e              state_q, state_d;
    logic [7:0]          remaining_q, remaining_d;
    logic                learn_en_q, learn_en_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [CHANNELS-1:0] spikes_q, spikes_d;
    logic                learn_q, learn_d;
    logic [VAL_W-1:0]    val_q [CHANNELS];
    logic [CHANNELS-1:0] cmp;
    logic [CHANNELS-1:0] hit;
    logic                wr_en;

    // Rotate left of a byte: upper byte of {x, x} << n.
    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Each channel sees the same LFSR byte rotated by its index, which keeps
    // channels decorrelated without a second generator.
    always_comb begin
        cmp = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cmp[i] = val_q[i] > VAL_W'(rotl8(lfsr_q[7:0], i % 8));
        end
    end

`ifdef SPIKE_ENC_REFRACTORY_EN
    logic [CHANNELS-1:0] refr_q, refr_d;

    // A flag set by a spike blocks the next compare of that channel, then clears.
    assign hit = cmp & ~refr_q;

    always_comb begin
        refr_d = refr_q;
        unique case (state_q)
            StRun:   refr_d = hit;
            StDone:  refr_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            refr_q <= '0;
        end else begin
            refr_q <= refr_d;
        end
    end
`else
    assign hit = cmp;
`endif

    // Loads are only accepted while idle; out-of-range channels are silently dropped.
    assign wr_en = load_valid && (state_q == StIdle) && (32'(load_chan) < CHANNELS);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                val_q[i] <= '0;
            end
        end else if (wr_en) begin
            val_q[load_chan] <= load_value;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        learn_en_d  = learn_en_q;
        lfsr_d      = lfsr_q;
        spikes_d    = spikes_q;
        learn_d     = learn_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    remaining_d = window;
                    learn_en_d  = learn_en;
                    lfsr_d      = SEED;
                    state_d     = (window == 8'd0) ? StDone : StRun;
                end
            end
            StRun: begin
                remaining_d = remaining_q - 8'd1;
                lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
                spikes_d    = hit;
                learn_d     = learn_en_q;
                if (remaining_q == 8'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                spikes_d = '0;
                learn_d  = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            learn_en_q  <= 1'b0;
            lfsr_q      <= SEED;
            spikes_q    <= '0;
            learn_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            learn_en_q  <= learn_en_d;
            lfsr_q      <= lfsr_d;
            spikes_q    <= spikes_d;
            learn_q     <= learn_d;
        end
    end

    assign spikes     = spikes_q;
    assign learn      = learn_q;
    assign busy       = (state_q == StRun);
    assign done       = (state_q == StDone);
    assign load_ready = (state_q == StIdle);

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: reset behaviour, window timing,
// load handshake, spike trains against an LFSR reference model, determinism,
// learn pin and the optional refractory period.

module tb_spike_rate_encoder;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [2:0] load_chan;
    logic [7:0] load_value;
    logic       start;
    logic [7:0] window;
    logic       learn_en;
    logic [7:0] spikes;
    logic       learn;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    logic [7:0] mv    [8];
    logic [7:0] expq  [256];
    logic [7:0] trace [256];
    logic [7:0] saved [256];
    int         cnt   [8];
    int         mcnt  [8];
    int         pairs [8];

    spike_rate_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_chan  (load_chan),
        .load_value (load_value),
        .start      (start),
        .window     (window),
        .learn_en   (learn_en),
        .spikes     (spikes),
        .learn      (learn),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic load(input logic [2:0] ch, input logic [7:0] v);
        load_valid = 1'b1;
        load_chan  = ch;
        load_value = v;
        tick();
        load_valid = 1'b0;
        mv[ch]     = v;
    endtask

    // Runs one window of n timesteps and checks every cycle from start+1 to
    // start+n+2. Optionally offers a load together with start (ld_start) or
    // holds a load offer throughout the window (ld_run, must be dropped).
    task automatic run_window(input int n, input logic le, input logic ld_run,
                              input logic ld_start, input logic [2:0] ld_ch,
                              input logic [7:0] ld_v);
        logic [15:0] m;
        logic [7:0]  r;
        logic [7:0]  ev;
        logic [7:0]  pv;
        if (ld_start) mv[ld_ch] = ld_v;
        m  = SEED;
        pv = 8'h00;
        for (int c = 0; c < 8; c++) begin
            mcnt[c]  = 0;
            cnt[c]   = 0;
            pairs[c] = 0;
        end
        for (int j = 0; j < n; j++) begin
            for (int c = 0; c < 8; c++) begin
                r = m[7:0];
                for (int s = 0; s < c; s++) r = {r[6:0], r[7]};
                ev[c] = (mv[c] > r);
`ifdef SPIKE_ENC_REFRACTORY_EN
                if (pv[c]) ev[c] = 1'b0;
`endif
                if (ev[c]) mcnt[c]++;
            end
            pv      = ev;
            expq[j] = ev;
            if (m[0]) m = (m >> 1) ^ 16'hB400;
            else      m = m >> 1;
        end

        start    = 1'b1;
        window   = 8'(n);
        learn_en = le;
        if (ld_start) begin
            load_valid = 1'b1;
            load_chan  = ld_ch;
            load_value = ld_v;
        end
        tick();
        start      = 1'b0;
        load_valid = ld_run;
        load_chan  = ld_ch;
        load_value = ld_v;

        for (int k = 1; k <= n + 2; k++) begin
            chk($sformatf("busy w%0d k%0d", n, k), 32'(busy), 32'(k <= n));
            chk($sformatf("done w%0d k%0d", n, k), 32'(done), 32'(k == n + 1));
            chk($sformatf("load_ready w%0d k%0d", n, k), 32'(load_ready), 32'(k == n + 2));
            if (k >= 2 && k <= n + 1) begin
                chk($sformatf("spikes w%0d k%0d", n, k), 32'(spikes), 32'(expq[k-2]));
                chk($sformatf("learn w%0d k%0d", n, k), 32'(learn), 32'(le));
                trace[k-2] = spikes;
                for (int c = 0; c < 8; c++) begin
                    if (spikes[c]) cnt[c]++;
                    if (k >= 3 && spikes[c] && trace[k-3][c]) pairs[c]++;
                end
            end else begin
                chk($sformatf("spikes_off w%0d k%0d", n, k), 32'(spikes), 32'h0);
                chk($sformatf("learn_off w%0d k%0d", n, k), 32'(learn), 32'h0);
            end
            if (k == n + 1) load_valid = 1'b0;
            tick();
        end
    endtask

    initial begin
        reset      = 1'b0;
        load_valid = 1'b0;
        load_chan  = 3'd0;
        load_value = 8'd0;
        start      = 1'b0;
        window     = 8'd0;
        learn_en   = 1'b0;
        for (int c = 0; c < 8; c++) mv[c] = 8'd0;

        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("por spikes", 32'(spikes), 32'h0);
        chk("por busy", 32'(busy), 32'h0);
        chk("por done", 32'(done), 32'h0);
        chk("por learn", 32'(learn), 32'h0);
        chk("por load_ready", 32'(load_ready), 32'h1);

        // Reset in the middle of a long window.
        load(3'd0, 8'd200);
        start    = 1'b1;
        window   = 8'd50;
        learn_en = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("midrun busy", 32'(busy), 32'h1);
        chk("midrun learn", 32'(learn), 32'h1);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        chk("rst spikes", 32'(spikes), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        chk("rst learn", 32'(learn), 32'h0);
        chk("rst load_ready", 32'(load_ready), 32'h1);
        tick();
        chk("post rst load_ready", 32'(load_ready), 32'h1);
        chk("post rst busy", 32'(busy), 32'h0);
        for (int c = 0; c < 8; c++) mv[c] = 8'd0;
        run_window(20, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        chk("val cleared ch0 count", 32'(cnt[0]), 32'd0);

        // Rate extremes over a full 255-step window.
        load(3'd0, 8'd0);
        load(3'd1, 8'd255);
        load(3'd2, 8'd128);
        load(3'd3, 8'd64);
        run_window(255, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        chk("ch0 zero count", 32'(cnt[0]), 32'd0);
        // Seed low byte 0xE1 -> r = E1, C3, 87, 0F for channels 0..3.
        chk("first vector", 32'(trace[0]), 32'h0A);
`ifdef SPIKE_ENC_REFRACTORY_EN
        chk("second vector", 32'(trace[1]), 32'h00);
`else
        // Next LFSR state 0xE270 -> r = 70, E0, C1, 83.
        chk("second vector", 32'(trace[1]), 32'h02);
        chk("ch2 rate window", 32'(cnt[2] >= 108 && cnt[2] <= 148), 32'h1);
`endif
        chk("ch2 count vs model", 32'(cnt[2]), 32'(mcnt[2]));
        chk("ch1 count vs model", 32'(cnt[1]), 32'(mcnt[1]));

        // Plain timing windows.
        run_window(10, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        run_window(0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);

        // Load offered during RUN must be ignored.
        run_window(10, 1'b1, 1'b1, 1'b0, 3'd0, 8'hFF);
        run_window(10, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        chk("run load dropped ch0", 32'(cnt[0]), 32'd0);

        // Load together with start is used from the first RUN step.
        run_window(8, 1'b1, 1'b0, 1'b1, 3'd4, 8'd200);
        chk("start+load first vector", 32'(trace[0]), 32'h1A);

        // Identical windows give identical trains.
        run_window(32, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        for (int j = 0; j < 32; j++) saved[j] = trace[j];
        run_window(32, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        for (int j = 0; j < 32; j++) begin
            chk($sformatf("repeat step %0d", j), 32'(trace[j]), 32'(saved[j]));
        end
        run_window(32, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);

        // Channel 1 at full intensity.
        run_window(40, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
`ifdef SPIKE_ENC_REFRACTORY_EN
        chk("ch1 no consecutive spikes", 32'(pairs[1]), 32'd0);
        chk("ch1 count <= 20", 32'(cnt[1] <= 20), 32'h1);
`else
        chk("ch1 consecutive spikes seen", 32'(pairs[1] > 0), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
